// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings,
// parameter legal ranges and derived counter widths.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LOAD  = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  localparam int PC_W_MIN     = 4;
  localparam int PC_W_MAX     = 16;
  localparam int EXEC_CYC_MIN = 1;
  localparam int EXEC_CYC_MAX = 15;
  localparam int WAIT_MAX_MIN = 1;
  localparam int WAIT_MAX_MAX = 255;

  // Counters are sized for the largest legal parameter so widths never change
  localparam int WCNT_W = $clog2(WAIT_MAX_MAX + 1);
  localparam int ECNT_W = $clog2(EXEC_CYC_MAX + 1);

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with clear, load and wrap-around increment.
module pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            inc,
  input  logic            ld,
  input  logic [PC_W-1:0] ld_val,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (clr)      pc_d = '0;
    else if (ld)  pc_d = ld_val;
    else if (inc) pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Fetch/execute sequencer: drives instruction RAM reads, stage register loads
// and PC updates, with a bounded wait for RAM and an absorbing HALT.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int EXEC_CYC = 1,
  parameter int WAIT_MAX = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            mem_ready,
  input  logic            stall,
  input  logic            halt_op,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            ram_en,
  output logic            ram_rd,
  output logic            ram_wr,
  output logic            stage_ld,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic            timeout_err
);

  if (!(in_range(PC_W, PC_W_MIN, PC_W_MAX) &&
        in_range(EXEC_CYC, EXEC_CYC_MIN, EXEC_CYC_MAX) &&
        in_range(WAIT_MAX, WAIT_MAX_MIN, WAIT_MAX_MAX))) begin : g_bad_param
    $error("fetch_seq: parameter outside legal range");
  end

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [ECNT_W-1:0] EXEC_INIT = ECNT_W'(EXEC_CYC - 1);

  state_e            state_d, state_q;
  logic [WCNT_W-1:0] wcnt_d, wcnt_q;
  logic [ECNT_W-1:0] ecnt_d, ecnt_q;
  logic              tmo_d, tmo_q;
  logic              pc_inc, pc_ld;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ecnt_d  = ecnt_q;
    tmo_d   = tmo_q;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_LOAD;
        else begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      // Data arriving on the limit cycle still wins over the timeout
      S_WAIT: begin
        if (mem_ready) state_d = S_LOAD;
        else if (wcnt_q == WAIT_LAST) begin
          state_d = S_HALT;
          tmo_d   = 1'b1;
        end else wcnt_d = wcnt_q + 1'b1;
      end
      S_LOAD: begin
        pc_inc  = 1'b1;
        ecnt_d  = EXEC_INIT;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!stall) begin
          if (ecnt_q != '0) ecnt_d = ecnt_q - 1'b1;
          else if (halt_op) state_d = S_HALT;
          else begin
            pc_ld   = branch_taken;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ecnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ecnt_q  <= ecnt_d;
      tmo_q   <= tmo_d;
    end
  end

  pc_reg #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .clr    (1'b0),
    .inc    (pc_inc),
    .ld     (pc_ld),
    .ld_val (branch_target),
    .pc     (pc)
  );

  // Strobes decode the registered state only
  assign ram_en      = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign ram_rd      = ram_en;
  assign ram_wr      = 1'b0;
  assign stage_ld    = (state_q == S_LOAD);
  assign halted      = (state_q == S_HALT);
  assign state       = state_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed checks of fetch_seq: one narrow-PC single-cycle-exec instance and
// one 8-bit-PC three-cycle-exec instance share the same input stimulus.
module tb_fetch_seq;

  logic clk = 1'b0;
  logic reset, run, mem_ready, stall, halt_op, branch_taken;
  logic [7:0] bt;

  logic       a_ram_en, a_ram_rd, a_ram_wr, a_stage_ld, a_halted, a_tmo;
  logic [3:0] a_pc;
  logic [2:0] a_state;
  logic       b_ram_en, b_ram_rd, b_ram_wr, b_stage_ld, b_halted, b_tmo;
  logic [7:0] b_pc;
  logic [2:0] b_state;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_seq #(.PC_W(4), .EXEC_CYC(1), .WAIT_MAX(7)) dut_a (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .stall(stall),
    .halt_op(halt_op), .branch_taken(branch_taken), .branch_target(bt[3:0]),
    .ram_en(a_ram_en), .ram_rd(a_ram_rd), .ram_wr(a_ram_wr), .stage_ld(a_stage_ld),
    .pc(a_pc), .state(a_state), .halted(a_halted), .timeout_err(a_tmo)
  );

  fetch_seq #(.PC_W(8), .EXEC_CYC(3), .WAIT_MAX(7)) dut_b (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .stall(stall),
    .halt_op(halt_op), .branch_taken(branch_taken), .branch_target(bt),
    .ram_en(b_ram_en), .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .stage_ld(b_stage_ld),
    .pc(b_pc), .state(b_state), .halted(b_halted), .timeout_err(b_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; stall = 1'b0;
    halt_op = 1'b0; branch_taken = 1'b0; bt = 8'h00;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    do_reset();
    chk("rst_state", a_state, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_strobes", {a_ram_en, a_ram_rd, a_ram_wr, a_stage_ld}, 0);
    chk("rst_flags", {a_halted, a_tmo}, 0);

    // Back-to-back fetches, zero wait states: LOAD every 3 cycles
    run = 1'b1; mem_ready = 1'b1;
    tick();
    chk("first_fetch", a_state, 1);
    chk("fetch_ram", {a_ram_en, a_ram_rd, a_ram_wr}, 3'b110);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("load_stage_ld", a_stage_ld, 1);
      chk("load_pc", a_pc, k);
      tick();
      chk("exec_state", a_state, 4);
      chk("exec_pc", a_pc, k + 1);
      chk("exec_stage_ld", a_stage_ld, 0);
      tick();
      chk("refetch", a_state, 1);
    end

    // Reset asynchronously on the third WAIT cycle
    mem_ready = 1'b0;
    tick(); tick(); tick();
    chk("wait3_state", a_state, 2);
    chk("wait3_pc", a_pc, 4);
    #2 reset = 1'b1;
    #1;
    chk("async_state", a_state, 0);
    chk("async_pc", a_pc, 0);
    chk("async_strobes", {a_ram_en, a_ram_rd, a_stage_ld}, 0);
    reset = 1'b0; run = 1'b0;
    tick();
    chk("post_rst_state", a_state, 0);
    chk("post_rst_pc", a_pc, 0);

    // Fetch timeout: HALT 8 cycles after FETCH, then absorbing
    run = 1'b1;
    tick();
    chk("to_fetch", a_state, 1);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("to_wait", a_state, 2);
      chk("to_no_err", a_tmo, 0);
    end
    tick();
    chk("to_halt", a_state, 5);
    chk("to_flags", {a_halted, a_tmo}, 2'b11);
    chk("to_strobes", {a_ram_en, a_ram_rd, a_stage_ld}, 0);
    for (int i = 0; i < 4; i++) begin
      run = i[0]; mem_ready = 1'b1;
      tick();
      chk("halt_absorb", {a_state, a_halted}, {3'd5, 1'b1});
    end

    // mem_ready on the limit cycle wins
    do_reset();
    run = 1'b1;
    tick();
    repeat (7) tick();
    chk("lim_wait", a_state, 2);
    mem_ready = 1'b1;
    tick();
    chk("lim_load", a_state, 3);
    chk("lim_no_err", a_tmo, 0);

    // Narrow PC wraps 15 -> 0, then halt_op beats branch_taken
    do_reset();
    run = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; bt = 8'h0F;
    tick(); tick(); tick();
    chk("br_exec_pc", a_pc, 1);
    tick();
    chk("br_fetch_pc", a_pc, 15);
    branch_taken = 1'b0;
    tick();
    chk("wrap_load", {a_stage_ld, a_pc}, {1'b1, 4'hF});
    tick();
    chk("wrap_pc", a_pc, 0);
    chk("wrap_no_x", $isunknown({a_ram_en, a_ram_rd, a_ram_wr, a_stage_ld, a_pc,
                                 a_state, a_halted, a_tmo}), 0);
    halt_op = 1'b1; branch_taken = 1'b1; bt = 8'h09;
    tick();
    chk("halt_state", a_state, 5);
    chk("halt_pc", a_pc, 0);
    chk("halt_flags", {a_halted, a_tmo}, 2'b10);
    halt_op = 1'b0; branch_taken = 1'b0;
    tick();
    chk("halt_stay", {a_state, a_ram_en}, {3'd5, 1'b0});

    // Three-cycle execute with a 4-cycle stall, then branch redirect
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    tick();
    chk("b_fetch", b_state, 1);
    tick();
    chk("b_load", b_stage_ld, 1);
    tick();
    chk("b_exec", {b_state, b_pc}, {3'd4, 8'h01});
    branch_taken = 1'b1; bt = 8'h5A;
    n = 0;
    while (b_state == 3'd4 && n < 20) begin
      stall = (n >= 1 && n <= 4);
      tick();
      n++;
    end
    stall = 1'b0; branch_taken = 1'b0;
    chk("b_exec_len", n, 7);
    chk("b_br_state", b_state, 1);
    chk("b_br_pc", b_pc, 8'h5A);
    repeat (5) tick();
    chk("b_latency", b_state, 1);
    chk("b_next_pc", b_pc, 8'h5B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
